// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned PC_STEP = 2;

    typedef enum logic [2:0] {
        RESET_WAIT,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;

    // Instruction handed to decode together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_instr_t;

    // Carry-lookahead add/subtract: generate/propagate per bit, carry chain from is_sub.
    function automatic logic [ADDR_W-1:0] cla_add_sub(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic              is_sub
    );
        logic [ADDR_W-1:0] bx;
        logic [ADDR_W-1:0] g;
        logic [ADDR_W-1:0] p;
        logic [ADDR_W:0]   c;
        bx   = is_sub ? ~b : b;
        g    = a & bx;
        p    = a ^ bx;
        c    = '0;
        c[0] = is_sub;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_incr.sv
// Sequential-PC incrementer: pc + PC_STEP through the shared add/sub unit.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_c
);

    localparam logic IS_SUB = 1'b0;

    assign pc_next_c = cla_add_sub(pc, ADDR_W'(PC_STEP), IS_SUB);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: fetches one instruction at a time over req/gnt/rvalid
// and hands it to decode over valid/ready; handles redirects and sticky halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    fetch_state_e      resume_state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus_c;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              squash_q;
    logic              squash_d;
    logic              halt_pend_q;
    fetch_instr_t      held_q;
    fetch_instr_t      held_d;
    logic [15:0]       count_d;

    pc_incr u_pc_incr (
        .pc        (pc_q),
        .pc_next_c (pc_plus_c)
    );

    // Next-state, PC and capture logic; redirect outranks halt, halt outranks normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        held_d       = held_q;
        count_d      = fetch_count;
        redirect_tgt = {redirect_pc[ADDR_W-1:1], 1'b0};
        resume_state = halt_pend_q ? HALT : REQ;

        case (state_q)
            RESET_WAIT: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_tgt;
            end
            REQ: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (imem_gnt) begin
                    state_d  = WAIT;
                    squash_d = redirect_valid;
                end else if (halt_pend_q) begin
                    state_d = HALT;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (imem_rvalid) begin
                    if (squash_q || halt_pend_q || redirect_valid) begin
                        squash_d = 1'b0;
                        state_d  = resume_state;
                    end else begin
                        held_d.word = imem_rdata;
                        held_d.pc   = pc_q;
                        state_d     = HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = resume_state;
                end else if (instr_ready) begin
                    pc_d    = pc_plus_c;
                    count_d = fetch_count + 16'd1;
                    state_d = resume_state;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase
    end

    // State and output registers; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_WAIT;
            pc_q        <= {RESET_PC[ADDR_W-1:1], 1'b0};
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            held_q      <= '0;
            fetch_count <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            halt_pend_q <= halt_pend_q | halt;
            held_q      <= held_d;
            fetch_count <= count_d;
            imem_req    <= (state_d == REQ);
            instr_valid <= (state_d == HOLD);
            halted      <= (state_d == HALT);
        end
    end

    assign imem_addr = pc_q;
    assign instr     = held_q.word;
    assign instr_pc  = held_q.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences and a
// randomized run, all checked against a transaction-level model of the sequencer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: where the sequencer is in its fetch transaction.
    bit          m_boot, m_fetch, m_wait, m_hold, m_halted, m_drop, m_hp;
    logic [15:0] m_pc, m_cnt, m_instr, m_ipc;
    // Memory model: one outstanding granted read.
    bit          mem_busy;
    logic [15:0] mem_addr, gnt_addr, salt;

    typedef struct {
        bit          g_en;
        bit          r_en;
        bit          rdy;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_ipc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] tgt;
        tgt = {redirect_pc[15:1], 1'b0};
        if (!rst_n) begin
            m_boot = 1; m_fetch = 0; m_wait = 0; m_hold = 0; m_halted = 0;
            m_drop = 0; m_hp = 0; m_pc = 16'h0000; m_cnt = 0; m_instr = 0; m_ipc = 0;
            mem_busy = 0;
            return;
        end
        if (m_halted) begin
        end else if (m_boot) begin
            m_boot = 0; m_fetch = 1;
            if (redirect_valid) m_pc = tgt;
        end else if (m_fetch) begin
            if (imem_gnt) begin m_fetch = 0; m_wait = 1; m_drop = redirect_valid; end
            else if (m_hp) begin m_fetch = 0; m_halted = 1; end
            if (redirect_valid) m_pc = tgt;
        end else if (m_wait) begin
            if (imem_rvalid) begin
                m_wait = 0;
                if (m_drop || m_hp || redirect_valid) begin
                    m_drop = 0;
                    if (m_hp) m_halted = 1; else m_fetch = 1;
                end else begin
                    m_instr = imem_rdata; m_ipc = m_pc; m_hold = 1;
                end
            end else if (redirect_valid) m_drop = 1;
            if (redirect_valid) m_pc = tgt;
        end else if (m_hold) begin
            if (redirect_valid || instr_ready) begin
                m_hold = 0;
                if (m_hp) m_halted = 1; else m_fetch = 1;
                if (redirect_valid) m_pc = tgt;
                else begin m_pc = m_pc + 16'd2; m_cnt = m_cnt + 16'd1; end
            end
        end
        m_hp = m_hp | halt;
        if (imem_rvalid) mem_busy = 0;
        if (imem_gnt) begin mem_busy = 1; mem_addr = gnt_addr; end
    endtask

    task automatic tick();
        logic [66:0] act, exp;
        @(posedge clk);
        model_step();
        #1;
        act = {imem_req, instr_valid, halted, imem_addr, instr, instr_pc, fetch_count};
        exp = {m_fetch, m_hold, m_halted, m_pc, m_instr, m_ipc, m_cnt};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model @%0t: got %h expected %h", $time, act, exp);
        end
    endtask

    // One cycle: memory grants/responds when enabled and legal, then clock.
    task automatic cyc(input bit g_en, input bit r_en, input bit rdy, input bit rv,
                       input logic [15:0] rpc, input bit h);
        imem_gnt       = g_en && m_fetch;
        gnt_addr       = imem_addr;
        imem_rvalid    = r_en && mem_busy;
        imem_rdata     = imem_rvalid ? (mem_addr ^ salt) : 16'h0000;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        tick();
    endtask

    task automatic idle_inputs();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req"},    16'(imem_req),    16'h0);
        chk({tag, ".addr"},   imem_addr,        16'h0000);
        chk({tag, ".valid"},  16'(instr_valid), 16'h0);
        chk({tag, ".instr"},  instr,            16'h0000);
        chk({tag, ".ipc"},    instr_pc,         16'h0000);
        chk({tag, ".halted"}, 16'(halted),      16'h0);
        chk({tag, ".count"},  fetch_count,      16'h0000);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv, h;
        logic [15:0] rpc;
        rst_n = 0;
        salt  = 16'h0000;
        idle_inputs();

        tbl[0]  = '{1, 1, 1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[1]  = '{1, 1, 1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[2]  = '{1, 1, 1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'd0};
        tbl[3]  = '{1, 1, 1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'd1};
        tbl[4]  = '{1, 1, 1, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'd1};
        tbl[5]  = '{1, 1, 1, 1'b0, 16'h0002, 1'b1, 16'h0002, 16'd1};
        tbl[6]  = '{1, 1, 1, 1'b1, 16'h0004, 1'b0, 16'h0002, 16'd2};
        tbl[7]  = '{1, 1, 1, 1'b0, 16'h0004, 1'b0, 16'h0002, 16'd2};
        tbl[8]  = '{1, 1, 1, 1'b0, 16'h0004, 1'b1, 16'h0004, 16'd2};
        tbl[9]  = '{1, 1, 1, 1'b1, 16'h0006, 1'b0, 16'h0004, 16'd3};
        tbl[10] = '{1, 1, 1, 1'b0, 16'h0006, 1'b0, 16'h0004, 16'd3};
        tbl[11] = '{1, 1, 1, 1'b0, 16'h0006, 1'b1, 16'h0006, 16'd3};
        tbl[12] = '{1, 1, 1, 1'b1, 16'h0008, 1'b0, 16'h0006, 16'd4};

        // Reset values, then 0-wait streaming with word = address.
        do_reset();
        chk_reset("reset");
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].g_en, tbl[i].r_en, tbl[i].rdy, 0, 16'h0000, 0);
            chk($sformatf("vec%0d.req", i),   16'(imem_req),    16'(tbl[i].exp_req));
            chk($sformatf("vec%0d.addr", i),  imem_addr,        tbl[i].exp_addr);
            chk($sformatf("vec%0d.valid", i), 16'(instr_valid), 16'(tbl[i].exp_valid));
            chk($sformatf("vec%0d.ipc", i),   instr_pc,         tbl[i].exp_ipc);
            chk($sformatf("vec%0d.instr", i), instr,            tbl[i].exp_ipc);
            chk($sformatf("vec%0d.count", i), fetch_count,      tbl[i].exp_cnt);
        end

        salt = 16'h5A00;

        // Grant held off three cycles at 0x0010.
        do_reset();
        cyc(0, 0, 0, 1, 16'h0010, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, 0);
            chk($sformatf("stall%0d.req", k),  16'(imem_req), 16'h1);
            chk($sformatf("stall%0d.addr", k), imem_addr,     16'h0010);
        end
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("stall.ipc",   instr_pc, 16'h0010);
        chk("stall.instr", instr,    16'h0010 ^ 16'h5A00);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 16'h0000, 0);
        chk("stall.count", fetch_count, 16'd1);
        chk("stall.addr",  imem_addr,   16'h0012);

        // Redirect while waiting on 0x0020: response dropped, refetch at 0x0100.
        do_reset();
        cyc(0, 0, 0, 1, 16'h0020, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 0, 0, 1, 16'h0101, 0);
        chk("wredir.req", 16'(imem_req), 16'h0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("wredir.addr",  imem_addr,        16'h0100);
        chk("wredir.req2",  16'(imem_req),    16'h1);
        chk("wredir.valid", 16'(instr_valid), 16'h0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("wredir.ipc",   instr_pc, 16'h0100);
        chk("wredir.instr", instr,    16'h0100 ^ 16'h5A00);

        // Redirect beats ready in HOLD at 0x0040.
        do_reset();
        cyc(0, 0, 0, 1, 16'h0040, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("hredir.ipc", instr_pc, 16'h0040);
        cyc(0, 0, 1, 1, 16'h0080, 0);
        chk("hredir.count", fetch_count,      16'd0);
        chk("hredir.addr",  imem_addr,        16'h0080);
        chk("hredir.valid", 16'(instr_valid), 16'h0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        cyc(0, 0, 1, 0, 16'h0000, 0);
        chk("hredir.count2", fetch_count, 16'd1);

        // PC wraps from 0xFFFE to 0x0000.
        do_reset();
        cyc(0, 0, 0, 1, 16'hFFFE, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("wrap.ipc", instr_pc, 16'hFFFE);
        cyc(0, 0, 1, 0, 16'h0000, 0);
        chk("wrap.addr", imem_addr, 16'h0000);
        chk("wrap.req",  16'(imem_req), 16'h1);

        // Halt pulsed in WAIT; redirects ignored once halted; reset recovers.
        do_reset();
        cyc(0, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        cyc(0, 0, 1, 0, 16'h0000, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 0, 0, 0, 16'h0000, 1);
        chk("halt.early", 16'(halted), 16'h0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        chk("halt.halted", 16'(halted),      16'h1);
        chk("halt.req",    16'(imem_req),    16'h0);
        chk("halt.valid",  16'(instr_valid), 16'h0);
        chk("halt.count",  fetch_count,      16'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 1, 1, 16'h0200, 0);
            chk($sformatf("halt%0d.req", k),  16'(imem_req), 16'h0);
            chk($sformatf("halt%0d.addr", k), imem_addr,     16'h0002);
        end
        do_reset();
        chk_reset("halt.reset");

        // Randomized traffic against the model, with occasional resets.
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            salt = 16'($urandom);
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    rst_n = 0;
                    tick();
                    rst_n = 1;
                end
                rv  = ($urandom_range(0, 9) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFC | 16'($urandom_range(0, 3)))
                                                  : 16'($urandom);
                h   = ($urandom_range(0, 149) == 0);
                cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) != 0, rv, rpc, h);
                if (m_halted && $urandom_range(0, 15) == 0) do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
